// File: rtl/led_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : led_write_arbiter
//  Description : Arbitrates LED register writes between two level-handshake
//                requesters (A = CPU MMIO, B = debug/test pattern). The
//                winner's 24-bit value is split into a low-half strobe
//                (bits [15:0]) and a high-half strobe (bits [23:16]). A
//                one-cycle ack then goes back to the winner.
//  Revision    : 1.0  initial release
// ============================================================================
module led_write_arbiter #(
    parameter bit RR_EN = 1'b1     // 1: round-robin, 0: A has fixed priority
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic [1:0]  a_mode,
    input  logic [23:0] a_data,

    input  logic        b_req,
    input  logic [1:0]  b_mode,
    input  logic [23:0] b_data,

    output logic        a_ack,
    output logic        b_ack,

    output logic        led_ctrl_low,
    output logic        led_ctrl_high,
    output logic [15:0] led_wdata,

    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic c_ID_A = 1'b0;
    localparam logic c_ID_B = 1'b1;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_mode;      // mode of the transaction in flight
    logic [23:0] r_data;      // data of the transaction in flight
    logic        r_owner;     // id of the current/last granted requester
    logic        r_last;      // round-robin history: id that completed last

    logic        w_any_req;
    logic        w_pick_b;
    logic        w_grant;
    logic [1:0]  w_sel_mode;
    logic [23:0] w_sel_data;

    // Arbitration: B wins alone, or on contention when round-robin is on and
    // A was the last one served. History resets to B so A wins first.
    always_comb begin
        w_any_req  = a_req | b_req;
        w_pick_b   = b_req & (~a_req | (RR_EN & (r_last == c_ID_A)));
        w_grant    = (r_state == IDLE) & w_any_req;
        w_sel_mode = w_pick_b ? b_mode : a_mode;
        w_sel_data = w_pick_b ? b_data : a_data;
    end

    // Next-state logic; transitions out of IDLE use the winner's live mode,
    // later states only look at the latched copy.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    if (w_sel_mode[0]) begin
                        w_state_next = WR_LO;
                    end else if (w_sel_mode[1]) begin
                        w_state_next = WR_HI;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            WR_LO:   w_state_next = r_mode[1] ? WR_HI : DONE;
            WR_HI:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register plus transaction latches; reset aborts anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_mode  <= 2'b00;
            r_data  <= 24'h000000;
            r_owner <= c_ID_B;
            r_last  <= c_ID_B;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_mode  <= w_sel_mode;
                r_data  <= w_sel_data;
                r_owner <= w_pick_b ? c_ID_B : c_ID_A;
            end
            if (r_state == DONE) begin
                r_last <= r_owner;
            end
        end
    end

    // Output decode from registered state and latches only, so no request
    // input can ripple through to an output in the same cycle.
    always_comb begin
        led_ctrl_low  = 1'b0;
        led_ctrl_high = 1'b0;
        led_wdata     = 16'h0000;
        a_ack         = 1'b0;
        b_ack         = 1'b0;
        case (r_state)
            WR_LO: begin
                led_ctrl_low = 1'b1;
                led_wdata    = r_data[15:0];
            end
            WR_HI: begin
                led_ctrl_high = 1'b1;
                led_wdata     = {8'h00, r_data[23:16]};
            end
            DONE: begin
                a_ack = (r_owner == c_ID_A);
                b_ack = (r_owner == c_ID_B);
            end
            default: begin
                led_wdata = 16'h0000;
            end
        endcase
        busy  = (r_state != IDLE);
        owner = r_owner;
    end

endmodule
`default_nettype wire

// File: tb/tb_led_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_write_arbiter
//  Description : Directed self-checking bench for led_write_arbiter. One
//                instance runs round-robin and one runs fixed priority; both
//                share the same requester stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_led_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0;
    logic [1:0]  a_mode = 2'b00;
    logic [23:0] a_data = 24'h0;
    logic        b_req = 1'b0;
    logic [1:0]  b_mode = 2'b00;
    logic [23:0] b_data = 24'h0;

    logic        a_ack1, b_ack1, low1, high1, busy1, owner1;
    logic [15:0] wdata1;
    logic        a_ack0, b_ack0, low0, high0, busy0, owner0;
    logic [15:0] wdata0;

    int vectors     = 0;
    int miscompares = 0;

    // Observation word: {low, high, wdata[15:0], a_ack, b_ack, busy, owner}
    logic [21:0] obs1, obs0;
    assign obs1 = {low1, high1, wdata1, a_ack1, b_ack1, busy1, owner1};
    assign obs0 = {low0, high0, wdata0, a_ack0, b_ack0, busy0, owner0};

    always #5 clk = ~clk;

    led_write_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_mode(a_mode), .a_data(a_data),
        .b_req(b_req), .b_mode(b_mode), .b_data(b_data),
        .a_ack(a_ack1), .b_ack(b_ack1),
        .led_ctrl_low(low1), .led_ctrl_high(high1), .led_wdata(wdata1),
        .busy(busy1), .owner(owner1)
    );

    led_write_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_mode(a_mode), .a_data(a_data),
        .b_req(b_req), .b_mode(b_mode), .b_data(b_data),
        .a_ack(a_ack0), .b_ack(b_ack0),
        .led_ctrl_low(low0), .led_ctrl_high(high0), .led_wdata(wdata0),
        .busy(busy0), .owner(owner0)
    );

    function automatic logic [21:0] pk(input logic lo, input logic hi,
                                       input logic [15:0] wd, input logic aa,
                                       input logic ba, input logic bz,
                                       input logic ow);
        return {lo, hi, wd, aa, ba, bz, ow};
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] e;
        rst = 1'b1;
        step();
        step();
        e = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (obs1 !== e) begin
            miscompares++;
            $display("FAIL reset_rr: got %h want %h", obs1, e);
        end
        vectors++;
        if (obs0 !== e) begin
            miscompares++;
            $display("FAIL reset_fp: got %h want %h", obs0, e);
        end
        rst = 1'b0;
    endtask

    task automatic test_two_half_write();
        logic [21:0] e [4];
        e[0] = pk(1'b1, 1'b0, 16'hCDEF, 1'b0, 1'b0, 1'b1, 1'b0);
        e[1] = pk(1'b0, 1'b1, 16'h00AB, 1'b0, 1'b0, 1'b1, 1'b0);
        e[2] = pk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        e[3] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        a_req = 1'b1; a_mode = 2'b11; a_data = 24'hABCDEF;
        for (int k = 0; k < 4; k++) begin
            step();
            vectors++;
            if (obs1 !== e[k]) begin
                miscompares++;
                $display("FAIL two_half c%0d: got %h want %h", k + 1, obs1, e[k]);
            end
            if (k == 2) a_req = 1'b0;
        end
    endtask

    task automatic test_zero_mode();
        logic [21:0] e [2];
        e[0] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        e[1] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        b_req = 1'b1; b_mode = 2'b00; b_data = 24'h777777;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if (obs1 !== e[k]) begin
                miscompares++;
                $display("FAIL zero_mode c%0d: got %h want %h", k + 1, obs1, e[k]);
            end
            if (k == 0) b_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] e [7];
        e[0] = pk(1'b1, 1'b0, 16'h579B, 1'b0, 1'b0, 1'b1, 1'b0);
        e[1] = pk(1'b0, 1'b1, 16'h0013, 1'b0, 1'b0, 1'b1, 1'b0);
        e[2] = pk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        e[3] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        e[4] = pk(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1);
        e[5] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        e[6] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        a_req = 1'b1; a_mode = 2'b11; a_data = 24'h13579B;
        for (int k = 0; k < 7; k++) begin
            step();
            vectors++;
            if (obs1 !== e[k]) begin
                miscompares++;
                $display("FAIL b2b_rr c%0d: got %h want %h", k + 1, obs1, e[k]);
            end
            vectors++;
            if (obs0 !== e[k]) begin
                miscompares++;
                $display("FAIL b2b_fp c%0d: got %h want %h", k + 1, obs0, e[k]);
            end
            if (k == 0) begin
                b_req = 1'b1; b_mode = 2'b01; b_data = 24'h00BEEF;
            end
            if (k == 2) a_req = 1'b0;
            if (k == 5) b_req = 1'b0;
        end
    endtask

    task automatic test_req_drop();
        logic [21:0] e [3];
        e[0] = pk(1'b0, 1'b1, 16'h005A, 1'b0, 1'b0, 1'b1, 1'b0);
        e[1] = pk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        e[2] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        a_req = 1'b1; a_mode = 2'b10; a_data = 24'h5A0000;
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (obs1 !== e[k]) begin
                miscompares++;
                $display("FAIL req_drop c%0d: got %h want %h", k + 1, obs1, e[k]);
            end
            if (k == 0) begin
                a_req = 1'b0; a_mode = 2'b11; a_data = 24'hFFFFFF;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [21:0] e [6];
        e[0] = pk(1'b1, 1'b0, 16'h3456, 1'b0, 1'b0, 1'b1, 1'b0);
        e[1] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        e[2] = pk(1'b1, 1'b0, 16'h3456, 1'b0, 1'b0, 1'b1, 1'b0);
        e[3] = pk(1'b0, 1'b1, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0);
        e[4] = pk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        e[5] = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        a_req = 1'b1; a_mode = 2'b11; a_data = 24'h123456;
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (obs1 !== e[k]) begin
                miscompares++;
                $display("FAIL rst_abort c%0d: got %h want %h", k + 1, obs1, e[k]);
            end
            if (k == 0) rst = 1'b1;
            if (k == 1) rst = 1'b0;
            if (k == 4) a_req = 1'b0;
        end
    endtask

    // Both requesters hold mode 01 continuously. Every transaction takes
    // three cycles (WR_LO, DONE, IDLE); the round-robin instance alternates
    // A,B,A,B while the fixed-priority instance serves A every time.
    task automatic test_contention();
        logic [21:0] er, ef, eidle;
        int ph;
        int id;
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_req = 1'b1; a_mode = 2'b01; a_data = 24'h111234;
        b_req = 1'b1; b_mode = 2'b01; b_data = 24'h225678;
        for (int k = 0; k < 11; k++) begin
            step();
            ph = k % 3;
            id = (k / 3) % 2;
            case (ph)
                0: begin
                    er = pk(1'b1, 1'b0, (id == 0) ? 16'h1234 : 16'h5678,
                            1'b0, 1'b0, 1'b1, id[0]);
                    ef = pk(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
                end
                1: begin
                    er = pk(1'b0, 1'b0, 16'h0000, (id == 0), (id == 1), 1'b1, id[0]);
                    ef = pk(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
                end
                default: begin
                    er = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, id[0]);
                    ef = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
                end
            endcase
            vectors++;
            if (obs1 !== er) begin
                miscompares++;
                $display("FAIL contend_rr c%0d: got %h want %h", k + 1, obs1, er);
            end
            vectors++;
            if (obs0 !== ef) begin
                miscompares++;
                $display("FAIL contend_fp c%0d: got %h want %h", k + 1, obs0, ef);
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        step();
        eidle = pk(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (obs1 !== eidle) begin
            miscompares++;
            $display("FAIL contend_rr_end: got %h want %h", obs1, eidle);
        end
    endtask

    initial begin
        test_reset();
        test_two_half_write();
        test_zero_mode();
        test_back_to_back();
        test_req_drop();
        test_reset_abort();
        test_contention();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/led_write_arbiter.md
LED_WRITE_ARBITER -- requirements
Module: led_write_arbiter

Interface
REQ-001 SHALL have parameter: RR_EN, 1, 1 = round-robin arbitration between A and B; 0 = fixed priority, A always wins.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: a_req  input  1, a_mode  input  2, a_data  input  24: requester A (CPU MMIO path); mode[0] = write low half, mode[1] = write high half.
REQ-005 SHALL have ports: b_req  input  1, b_mode  input  2, b_data  input  24: requester B (debug/test-pattern path), same meaning as A.
REQ-006 SHALL have ports: a_ack  output  1, b_ack  output  1: one-cycle completion pulse to the granted requester.
REQ-007 SHALL have port: led_ctrl_low  output  1  select strobe for LED bits [15:0].
REQ-008 SHALL have port: led_ctrl_high  output  1  select strobe for LED bits [23:16].
REQ-009 SHALL have port: led_wdata  output  16  write data to the LED register.
REQ-010 SHALL have ports: busy  output  1, owner  output  1 (0 = A, 1 = B, last/current grant).

Function
REQ-011 SHALL implement FSM states IDLE, WR_LO, WR_HI, DONE; all outputs decoded from registered state/latches only, with no combinational path from any *_req/*_mode/*_data input to any output.
REQ-012 Requests SHALL be level: a requester holds req, mode and data until its ack, and may drop req or issue a new request in the cycle after ack.
REQ-013 In IDLE with one req high, that requester SHALL be granted; with both high, RR_EN=1 grants the requester not granted last, RR_EN=0 grants A.
REQ-014 On grant, the block SHALL latch the winner's mode, data and id (owner) in the same edge; later input changes SHALL not affect the transaction.
REQ-015 IDLE transition on grant: mode[0]=1 -> WR_LO; mode=10 -> WR_HI; mode=00 -> DONE (no LED strobe).
REQ-016 WR_LO: led_ctrl_low=1, led_wdata=data[15:0]; next WR_HI if mode[1]=1, else DONE.
REQ-017 WR_HI: led_ctrl_high=1, led_wdata={8'h00, data[23:16]}; next DONE.
REQ-018 DONE: ack of latched owner =1 for exactly one cycle, the other ack =0; next IDLE; round-robin history updated to owner.
REQ-019 led_ctrl_low and led_ctrl_high SHALL never be high in the same cycle; led_wdata SHALL be 16'h0000 whenever neither strobe is high.
REQ-020 Latency from req sampled in IDLE (edge 0): mode 11 -> low strobe cycle 1, high strobe cycle 2, ack cycle 3; mode 01 or 10 -> strobe cycle 1, ack cycle 2; mode 00 -> ack cycle 1.
REQ-021 At least one IDLE cycle SHALL separate transactions; continuous mode-11 requests complete one per 4 cycles.
REQ-022 Dropping req mid-transaction SHALL be ignored: the transaction completes from latched values and ack still pulses.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Requests arriving while not in IDLE SHALL be held off (no ack, no strobe) until the next IDLE arbitration.

Reset
REQ-025 With rst high at a rising edge, next cycle: state IDLE, led_ctrl_low=0, led_ctrl_high=0, led_wdata=16'h0000, a_ack=b_ack=0, busy=0, owner=1 (so A wins the first contention).
REQ-026 Reset asserted mid-transaction SHALL abort it with no further strobes and no ack; the requester must re-request.

Verification
REQ-027 A mode 11 data 24'hABCDEF alone -> cycle1 led_ctrl_low=1 wdata 16'hCDEF; cycle2 led_ctrl_high=1 wdata 16'h00AB; cycle3 a_ack=1; b_ack stays 0.
REQ-028 A and B both req continuously, mode 01, RR_EN=1 -> grants A,B,A,B; each ack 3 cycles apart; owner alternates 0,1,0,1.
REQ-029 Same stimulus, RR_EN=0 -> A granted every transaction, b_ack never asserted while a_req high.
REQ-030 B mode 00 -> b_ack one cycle after sampling; no strobe at any time.
REQ-031 A mode 11, rst pulsed during WR_LO -> no led_ctrl_high, no a_ack, all outputs 0 next cycle; A re-request then completes normally.
REQ-032 A mode 10 data 24'h5A0000, a_data changed and a_req dropped after grant -> led_ctrl_high with wdata 16'h005A, a_ack still pulses.
